// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions, op-class bit, entry layout.
// The optional parity flag is controlled by ALU_PARITY_FLAG_EN in the flag generator.
package alu_pkg;

  localparam int ALU_N   = 8;
  localparam int ALU_OPW = 4;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_P = 4;
  localparam int FLAG_W = 5;

  // The top bit of the op tag separates logic-class ops from arithmetic ones.
  function automatic int op_class_bit(input int opw);
    return opw - 1;
  endfunction

  localparam int OP_CLASS_BIT = op_class_bit(ALU_OPW);

  typedef struct packed {
    logic [ALU_N-1:0]   result;
    logic [ALU_OPW-1:0] op;
    logic [FLAG_W-1:0]  flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator {P,N,Z,C,V} for one ALU result.
// P is only built when ALU_PARITY_FLAG_EN is defined; otherwise it is tied low.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int OPW = ALU_OPW
) (
  input  logic [N-1:0]      result,
  input  logic              carry,
  input  logic              ovf,
  input  logic [OPW-1:0]    op,
  output logic [FLAG_W-1:0] flags
);

  localparam int CLASS_BIT = op_class_bit(OPW);

  logic is_logic_op;
  logic parity;

  assign is_logic_op = op[CLASS_BIT];

`ifdef ALU_PARITY_FLAG_EN
  assign parity = ~(^result);
`else
  assign parity = 1'b0;
`endif

  // Logic-class ops never produce a meaningful carry or overflow.
  always_comb begin
    flags         = '0;
    flags[FLAG_V] = ovf & ~is_logic_op;
    flags[FLAG_C] = carry & ~is_logic_op;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[N-1];
    flags[FLAG_P] = parity;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag capture plus a main/skid register pair behind valid/ready.
// Define ALU_PARITY_FLAG_EN to populate out_flags[4] with the even-parity bit.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int OPW = ALU_OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic [OPW-1:0]    in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [OPW-1:0]    out_op,
  output logic [FLAG_W-1:0] out_flags
);

  typedef struct packed {
    logic [N-1:0]      result;
    logic [OPW-1:0]    op;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  entry_t            in_entry;
  logic [FLAG_W-1:0] in_flags;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic accept;
  logic pop;

  alu_flag_gen #(
    .N  (N),
    .OPW(OPW)
  ) u_flag_gen (
    .result(in_result),
    .carry (in_carry),
    .ovf   (in_ovf),
    .op    (in_op),
    .flags (in_flags)
  );

  assign in_entry.result = in_result;
  assign in_entry.op     = in_op;
  assign in_entry.flags  = in_flags;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  // Main only stalls when it is full and not popping; skid absorbs the one in-flight result.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || (pop && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_entry;
      end
    end else if (pop) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = accept;
      if (accept) begin
        skid_d = in_entry;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_op     = main_q.op;
  assign out_flags  = main_q.flags;

endmodule
